// File: rtl/opendap_pkg.sv
// Shared OpenDAP definitions: AP-controller state encoding and the field widths
// used on the DP-to-AP path.
package opendap_pkg;

    localparam int W_APC_STATE = 2;
    localparam int W_APSEL     = 8;
    localparam int W_APADDR    = 6;
    localparam int W_APDATA    = 32;
    localparam int W_TOCNT     = 8;

    typedef enum logic [W_APC_STATE-1:0] {
        APC_IDLE = 2'd0,
        APC_REQ  = 2'd1,
        APC_DONE = 2'd2
    } apc_state_e;

endpackage

// File: rtl/opendap_onehot_mux.sv
// One-hot N-way data selector; an all-zero select yields zero, so an idle or
// unmapped select can never leak data from an AP.
module opendap_onehot_mux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N-1:0]   i_sel,
    input  logic [N*W-1:0] i_data,
    output logic [W-1:0]   o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel[i]) begin
                o_data = o_data | i_data[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/opendap_ap_bus_ctrl.sv
// AP bus sequencer: latches one DP-issued AP access, runs the req/ack handshake
// with the selected AP and reports read data and error status back to the DP.
module opendap_ap_bus_ctrl
    import opendap_pkg::*;
#(
    parameter int N_AP    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   swclk,
    input  logic                   rst_n,
    input  logic [W_APSEL-1:0]     dp_ap_sel,
    input  logic [W_APADDR-1:0]    dp_ap_addr,
    input  logic [W_APDATA-1:0]    dp_ap_wdata,
    input  logic                   dp_ap_wen,
    input  logic                   dp_ap_ren,
    input  logic                   dp_ap_abort,
    output logic [W_APDATA-1:0]    dp_ap_rdata,
    output logic                   dp_ap_rdy,
    output logic                   dp_ap_err,
    output logic [N_AP-1:0]        ap_req,
    output logic                   ap_wen,
    output logic [W_APADDR-1:0]    ap_addr,
    output logic [W_APDATA-1:0]    ap_wdata,
    input  logic [N_AP-1:0]        ap_ack,
    input  logic [W_APDATA*N_AP-1:0] ap_rdata,
    input  logic [N_AP-1:0]        ap_err
);

    localparam logic [W_TOCNT-1:0] TO_VAL = W_TOCNT'(TIMEOUT);
    localparam bit                 TO_EN  = (TIMEOUT != 0);

    apc_state_e            r_state, w_state_nxt;
    logic [N_AP-1:0]       r_sel_oh, w_sel_oh_nxt, w_strobe_oh;
    logic [N_AP-1:0]       r_ap_req, w_ap_req_nxt;
    logic                  r_wen, w_wen_nxt;
    logic [W_APADDR-1:0]   r_addr, w_addr_nxt;
    logic [W_APDATA-1:0]   r_wdata, w_wdata_nxt;
    logic [W_APDATA-1:0]   r_rdata, w_rdata_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_rdy, w_rdy_nxt;
    logic [W_TOCNT-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [W_APDATA-1:0]   w_mux_data;
    logic                  w_strobe, w_mapped, w_ack, w_ap_err;

    // Decode APSEL straight to one-hot; values past N_AP decode to all-zero.
    always_comb begin
        w_strobe_oh = '0;
        for (int i = 0; i < N_AP; i++) begin
            w_strobe_oh[i] = (dp_ap_sel == W_APSEL'(i));
        end
    end

    assign w_strobe  = dp_ap_wen | dp_ap_ren;
    assign w_mapped  = |w_strobe_oh;
    assign w_ack     = |(ap_ack & r_sel_oh);
    assign w_ap_err  = |(ap_err & r_sel_oh);
    assign w_cnt_inc = r_cnt + W_TOCNT'(1);

    opendap_onehot_mux #(
        .N (N_AP),
        .W (W_APDATA)
    ) u_rdata_mux (
        .i_sel  (r_sel_oh),
        .i_data (ap_rdata),
        .o_data (w_mux_data)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_oh_nxt = r_sel_oh;
        w_ap_req_nxt = r_ap_req;
        w_wen_nxt    = r_wen;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = 1'b0;
        w_cnt_nxt    = r_cnt;

        case (r_state)
            APC_IDLE: begin
                if (w_strobe) begin
                    w_sel_oh_nxt = w_strobe_oh;
                    w_wen_nxt    = dp_ap_wen;
                    w_addr_nxt   = dp_ap_addr;
                    w_wdata_nxt  = dp_ap_wdata;
                    w_cnt_nxt    = '0;
                    if (w_mapped) begin
                        w_ap_req_nxt = w_strobe_oh;
                        w_state_nxt  = APC_REQ;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = APC_DONE;
                        if (!dp_ap_wen) begin
                            w_rdata_nxt = '0;
                        end
                    end
                end
            end
            APC_REQ: begin
                // Ack wins over a coincident abort, which wins over timeout.
                if (w_ack) begin
                    w_ap_req_nxt = '0;
                    w_err_nxt    = w_ap_err;
                    w_state_nxt  = APC_DONE;
                    if (!r_wen) begin
                        w_rdata_nxt = w_mux_data;
                    end
                end else if (dp_ap_abort) begin
                    w_ap_req_nxt = '0;
                    w_state_nxt  = APC_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (TO_EN && (w_cnt_inc == TO_VAL)) begin
                        w_ap_req_nxt = '0;
                        w_err_nxt    = 1'b1;
                        w_state_nxt  = APC_DONE;
                        if (!r_wen) begin
                            w_rdata_nxt = '0;
                        end
                    end
                end
            end
            APC_DONE: begin
                w_state_nxt = APC_IDLE;
            end
            default: begin
                w_ap_req_nxt = '0;
                w_state_nxt  = APC_IDLE;
            end
        endcase
    end

    assign w_rdy_nxt = (w_state_nxt == APC_IDLE);

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= APC_IDLE;
            r_sel_oh <= '0;
            r_ap_req <= '0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rdy    <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel_oh <= w_sel_oh_nxt;
            r_ap_req <= w_ap_req_nxt;
            r_wen    <= w_wen_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_rdata  <= w_rdata_nxt;
            r_err    <= w_err_nxt;
            r_rdy    <= w_rdy_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign dp_ap_rdata = r_rdata;
    assign dp_ap_rdy   = r_rdy;
    assign dp_ap_err   = r_err;
    assign ap_req      = r_ap_req;
    assign ap_wen      = r_wen;
    assign ap_addr     = r_addr;
    assign ap_wdata    = r_wdata;

endmodule

// File: tb/tb_opendap_ap_bus_ctrl.sv
// Bench for the AP bus sequencer: directed scenarios plus randomized accesses
// checked against an outcome model of each access.
module tb_opendap_ap_bus_ctrl;

    localparam int N_AP    = 4;
    localparam int TIMEOUT = 8;
    localparam int BUDGET  = 64;

    logic                 swclk = 1'b0;
    logic                 rst_n;
    logic [7:0]           dp_ap_sel;
    logic [5:0]           dp_ap_addr;
    logic [31:0]          dp_ap_wdata;
    logic                 dp_ap_wen, dp_ap_ren, dp_ap_abort;
    logic [31:0]          dp_ap_rdata;
    logic                 dp_ap_rdy, dp_ap_err;
    logic [N_AP-1:0]      ap_req;
    logic                 ap_wen;
    logic [5:0]           ap_addr;
    logic [31:0]          ap_wdata;
    logic [N_AP-1:0]      ap_ack;
    logic [32*N_AP-1:0]   ap_rdata;
    logic [N_AP-1:0]      ap_err;

    typedef struct {
        int          low;
        int          req;
        int          err;
        logic [31:0] rdata;
        bit          ok;
    } res_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_rdata  = '0;

    always #5 swclk = ~swclk;

    opendap_ap_bus_ctrl #(
        .N_AP    (N_AP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .swclk       (swclk),
        .rst_n       (rst_n),
        .dp_ap_sel   (dp_ap_sel),
        .dp_ap_addr  (dp_ap_addr),
        .dp_ap_wdata (dp_ap_wdata),
        .dp_ap_wen   (dp_ap_wen),
        .dp_ap_ren   (dp_ap_ren),
        .dp_ap_abort (dp_ap_abort),
        .dp_ap_rdata (dp_ap_rdata),
        .dp_ap_rdy   (dp_ap_rdy),
        .dp_ap_err   (dp_ap_err),
        .ap_req      (ap_req),
        .ap_wen      (ap_wen),
        .ap_addr     (ap_addr),
        .ap_wdata    (ap_wdata),
        .ap_ack      (ap_ack),
        .ap_rdata    (ap_rdata),
        .ap_err      (ap_err)
    );

    // Outcome of one access from its event times: the earliest of ack, abort and
    // timeout ends the request phase, ties going ack > abort > timeout.
    function automatic res_t model_access(input logic [7:0] sel, input bit wr,
                                          input int ack_k, input bit ack_err,
                                          input logic [31:0] data, input int abort_j);
        res_t e;
        int a, b, t;
        e.ok  = 1'b1;
        e.err = 0;
        if (int'(sel) >= N_AP) begin
            e.low = 1;
            e.req = 0;
            e.err = 1;
            if (!wr) m_rdata = '0;
        end else begin
            a = (ack_k > 0) ? ack_k : 1000;
            b = (abort_j > 0) ? abort_j : 1000;
            t = TIMEOUT;
            if (a <= b && a <= t) begin
                e.req = a;
                e.low = a + 1;
                e.err = ack_err ? 1 : 0;
                if (!wr) m_rdata = data;
            end else if (b <= t) begin
                e.req = b;
                e.low = b;
            end else begin
                e.req = t;
                e.low = t + 1;
                e.err = 1;
                if (!wr) m_rdata = '0;
            end
        end
        e.rdata = m_rdata;
        return e;
    endfunction

    task automatic drive_aps(input logic [7:0] sel, input bit ack_now, input bit ack_err,
                             input logic [31:0] data, input bit noise);
        for (int i = 0; i < N_AP; i++) begin
            ap_rdata[32*i +: 32] = $urandom;
            ap_err[i]            = 1'($urandom);
            ap_ack[i]            = noise ? 1'($urandom) : 1'b0;
        end
        if (int'(sel) < N_AP) begin
            ap_ack[sel[1:0]] = ack_now;
            if (ack_now) begin
                ap_rdata[32*int'(sel) +: 32] = data;
                ap_err[sel[1:0]]             = ack_err;
            end
        end
    endtask

    // Issues one access at a negedge and plays the APs/DP until rdy returns,
    // recording how long rdy was low, how long ap_req was up and err pulses.
    task automatic applyStimulus(input logic [7:0] sel, input bit wen, input bit ren,
                                 input logic [5:0] addr, input logic [31:0] wdata,
                                 input int ack_k, input bit ack_err, input logic [31:0] ack_data,
                                 input int abort_j, input bit noise, output res_t r);
        logic [N_AP-1:0] exp_oh;
        r.low = 0; r.req = 0; r.err = 0; r.ok = 1'b1; r.rdata = '0;
        exp_oh = (int'(sel) < N_AP) ? (N_AP'(1) << sel) : '0;
        dp_ap_sel = sel; dp_ap_addr = addr; dp_ap_wdata = wdata;
        dp_ap_wen = wen; dp_ap_ren = ren;
        @(negedge swclk);
        dp_ap_wen = 1'b0; dp_ap_ren = 1'b0;
        for (int c = 1; c <= BUDGET; c++) begin
            if (dp_ap_err) r.err++;
            if (dp_ap_rdy) break;
            r.low++;
            if (ap_req != '0) begin
                r.req++;
                if (ap_req !== exp_oh || ap_wen !== wen || ap_addr !== addr || ap_wdata !== wdata)
                    r.ok = 1'b0;
            end
            drive_aps(sel, (c == ack_k), ack_err, ack_data, noise);
            dp_ap_abort = (c == abort_j);
            if (noise) begin
                dp_ap_wen = 1'($urandom); dp_ap_ren = 1'($urandom);
                dp_ap_sel = 8'($urandom); dp_ap_addr = 6'($urandom);
                dp_ap_wdata = $urandom;
            end
            @(negedge swclk);
        end
        dp_ap_wen = 1'b0; dp_ap_ren = 1'b0; dp_ap_abort = 1'b0;
        ap_ack = '0;
        r.rdata = dp_ap_rdata;
    endtask

    task automatic test_reset();
        n_checks++; if (dp_ap_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset rdy: got %b expected 1", dp_ap_rdy); end
        n_checks++; if (dp_ap_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset err: got %b expected 0", dp_ap_err); end
        n_checks++; if (ap_req !== '0) begin n_fail++; $display("[TB] FAIL reset ap_req: got %b expected 0", ap_req); end
        n_checks++; if (dp_ap_rdata !== '0) begin n_fail++; $display("[TB] FAIL reset rdata: got %h expected 0", dp_ap_rdata); end
        n_checks++; if (ap_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset ap_wen: got %b expected 0", ap_wen); end
        n_checks++; if (ap_addr !== '0) begin n_fail++; $display("[TB] FAIL reset ap_addr: got %h expected 0", ap_addr); end
        n_checks++; if (ap_wdata !== '0) begin n_fail++; $display("[TB] FAIL reset ap_wdata: got %h expected 0", ap_wdata); end
    endtask

    task automatic test_access(input string name, input logic [7:0] sel, input bit wen, input bit ren,
                               input int ack_k, input bit ack_err, input logic [31:0] data,
                               input int abort_j, input bit noise);
        res_t o, e;
        logic [5:0]  addr  = 6'($urandom);
        logic [31:0] wdata = $urandom;
        if (name == "write_ap1") begin addr = 6'h04; wdata = 32'hCAFEF00D; end
        applyStimulus(sel, wen, ren, addr, wdata, ack_k, ack_err, data, abort_j, noise, o);
        e = model_access(sel, wen, ack_k, ack_err, data, abort_j);
        n_checks++; if (o.low !== e.low) begin n_fail++; $display("[TB] FAIL %s rdy_low_cycles: got %0d expected %0d", name, o.low, e.low); end
        n_checks++; if (o.req !== e.req) begin n_fail++; $display("[TB] FAIL %s req_cycles: got %0d expected %0d", name, o.req, e.req); end
        n_checks++; if (o.err !== e.err) begin n_fail++; $display("[TB] FAIL %s err_pulses: got %0d expected %0d", name, o.err, e.err); end
        n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL %s rdata: got %h expected %h", name, o.rdata, e.rdata); end
        n_checks++; if (o.ok !== e.ok) begin n_fail++; $display("[TB] FAIL %s req_onehot_stable: got %0d expected %0d", name, o.ok, e.ok); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int   kind  = int'($urandom_range(0, 2));
            int   ack_k = int'($urandom_range(0, 11));
            int   ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            test_access("rand", 8'($urandom_range(0, 5)), (kind != 1), (kind != 0),
                        ack_k, 1'($urandom), $urandom, ab, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        dp_ap_sel = 8'd1; dp_ap_ren = 1'b1; dp_ap_addr = 6'h08;
        @(negedge swclk);
        dp_ap_ren = 1'b0;
        @(negedge swclk);
        n_checks++; if (ap_req !== 4'b0010) begin n_fail++; $display("[TB] FAIL rst_mid pre ap_req: got %b expected 0010", ap_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ap_req !== '0) begin n_fail++; $display("[TB] FAIL rst_mid ap_req: got %b expected 0", ap_req); end
        n_checks++; if (dp_ap_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid rdy: got %b expected 1", dp_ap_rdy); end
        @(negedge swclk);
        rst_n = 1'b1;
        m_rdata = '0;
        @(negedge swclk);
        n_checks++; if (dp_ap_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid post rdy: got %b expected 1", dp_ap_rdy); end
        n_checks++; if (dp_ap_rdata !== m_rdata) begin n_fail++; $display("[TB] FAIL rst_mid rdata: got %h expected %h", dp_ap_rdata, m_rdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        dp_ap_sel = '0; dp_ap_addr = '0; dp_ap_wdata = '0;
        dp_ap_wen = 1'b0; dp_ap_ren = 1'b0; dp_ap_abort = 1'b0;
        ap_ack = '0; ap_rdata = '0; ap_err = '0;
        repeat (2) @(negedge swclk);
        rst_n = 1'b1;
        @(negedge swclk);

        test_reset();
        test_access("write_ap1", 8'd1, 1'b1, 1'b0, 3, 1'b0, 32'h0, 0, 1'b0);
        test_access("read_ap2", 8'd2, 1'b0, 1'b1, 1, 1'b0, 32'h12345678, 0, 1'b1);
        test_access("unmapped", 8'h10, 1'b0, 1'b1, 0, 1'b0, 32'h0, 0, 1'b0);
        test_access("timeout_ap3", 8'd3, 1'b0, 1'b1, 0, 1'b0, 32'h0, 0, 1'b0);
        test_access("after_timeout", 8'd0, 1'b0, 1'b1, 2, 1'b0, 32'hA5A5_0F0F, 0, 1'b0);
        test_access("abort", 8'd0, 1'b0, 1'b1, 0, 1'b0, 32'h0, 3, 1'b0);
        test_access("abort_with_ack", 8'd1, 1'b0, 1'b1, 2, 1'b0, 32'h0BAD_CAFE, 2, 1'b0);
        test_access("ap_err", 8'd2, 1'b0, 1'b1, 2, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        test_access("both_strobes", 8'd3, 1'b1, 1'b1, 1, 1'b0, 32'h1111_2222, 0, 1'b0);
        test_random();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
